// File: rtl/ijtag_sib_tdr.sv
// IEEE 1687 Segment Insertion Bit with a gated Test Data Register.
//
// The SIB bit always sits in the scan path. When its update bit (sib_open)
// is set, a DATA_WIDTH-bit TDR is spliced in ahead of it. The TDR captures
// status_in and writes a shadowed control word on update.
//
// Ports:
//   TCK, TRST_n        test clock (posedge) and async active-low reset
//   ijtag_select       segment selected; other controls ignored while low
//   ijtag_capture      CAPTURE-DR (rising-edge detected)
//   ijtag_shift        SHIFT-DR (level, one bit per cycle)
//   ijtag_update       UPDATE-DR (rising-edge detected)
//   ijtag_tdi          scan data in
//   ijtag_tdo          scan data out, straight from the SIB shift flop
//   status_in          instrument status, sampled on capture while open
//   ctrl_out           shadow control register
//   ctrl_strobe        one-cycle pulse following each ctrl_out write
//   sib_open           SIB update bit; 1 = TDR in path
//   update_count       saturating count of ctrl_out writes
module ijtag_sib_tdr #(
    parameter int unsigned              DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic                  TCK,
    input  logic                  TRST_n,
    input  logic                  ijtag_select,
    input  logic                  ijtag_capture,
    input  logic                  ijtag_shift,
    input  logic                  ijtag_update,
    input  logic                  ijtag_tdi,
    output logic                  ijtag_tdo,
    input  logic [DATA_WIDTH-1:0] status_in,
    output logic [DATA_WIDTH-1:0] ctrl_out,
    output logic                  ctrl_strobe,
    output logic                  sib_open,
    output logic [7:0]            update_count
);

    logic                  sib_sr_q, sib_sr_d;
    logic                  sib_open_q, sib_open_d;
    logic [DATA_WIDTH-1:0] tdr_sr_q, tdr_sr_d;
    logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                  strobe_q, strobe_d;
    logic [7:0]            count_q, count_d;
    logic                  cap_prev_q, cap_prev_d;
    logic                  upd_prev_q, upd_prev_d;

    logic cap, sh, upd;
    logic do_cap, do_sh, do_upd;

    always_comb begin
        cap = ijtag_select & ijtag_capture;
        sh  = ijtag_select & ijtag_shift;
        upd = ijtag_select & ijtag_update;

        // Priority capture > shift > update; only the winner acts.
        do_cap = cap & ~cap_prev_q;
        do_sh  = sh & ~do_cap;
        do_upd = upd & ~upd_prev_q & ~do_cap & ~sh;

        sib_sr_d   = sib_sr_q;
        sib_open_d = sib_open_q;
        tdr_sr_d   = tdr_sr_q;
        ctrl_d     = ctrl_q;
        strobe_d   = 1'b0;
        count_d    = count_q;
        // Flags follow the qualified levels, so they clear while deselected.
        cap_prev_d = cap;
        upd_prev_d = upd;

        if (do_cap) begin
            sib_sr_d = sib_open_q;
            if (sib_open_q) begin
                tdr_sr_d = status_in;
            end
        end else if (do_sh) begin
            if (sib_open_q) begin
                tdr_sr_d = {ijtag_tdi, tdr_sr_q[DATA_WIDTH-1:1]};
                sib_sr_d = tdr_sr_q[0];
            end else begin
                sib_sr_d = ijtag_tdi;
            end
        end else if (do_upd) begin
            sib_open_d = sib_sr_q;
            // Gate on the pre-update open bit: it defined the path that was scanned.
            if (sib_open_q) begin
                ctrl_d   = tdr_sr_q;
                strobe_d = 1'b1;
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            sib_sr_q   <= 1'b0;
            sib_open_q <= 1'b0;
            tdr_sr_q   <= '0;
            ctrl_q     <= RESET_VALUE;
            strobe_q   <= 1'b0;
            count_q    <= 8'd0;
            cap_prev_q <= 1'b0;
            upd_prev_q <= 1'b0;
        end else begin
            sib_sr_q   <= sib_sr_d;
            sib_open_q <= sib_open_d;
            tdr_sr_q   <= tdr_sr_d;
            ctrl_q     <= ctrl_d;
            strobe_q   <= strobe_d;
            count_q    <= count_d;
            cap_prev_q <= cap_prev_d;
            upd_prev_q <= upd_prev_d;
        end
    end

    assign ijtag_tdo    = sib_sr_q;
    assign sib_open     = sib_open_q;
    assign ctrl_out     = ctrl_q;
    assign ctrl_strobe  = strobe_q;
    assign update_count = count_q;

endmodule

// File: tb/tb_ijtag_sib_tdr.sv
// Bench for ijtag_sib_tdr: a per-cycle vector table for single-cycle control
// behaviour, hand sequences for scans, and a queue of expected tdo bits.
module tb_ijtag_sib_tdr;

    logic       TCK;
    logic       TRST_n;
    logic       ijtag_select, ijtag_capture, ijtag_shift, ijtag_update, ijtag_tdi;
    logic       ijtag_tdo;
    logic [7:0] status_in;
    logic [7:0] ctrl_out;
    logic       ctrl_strobe;
    logic       sib_open;
    logic [7:0] update_count;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    ijtag_sib_tdr #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .TCK           (TCK),
        .TRST_n        (TRST_n),
        .ijtag_select  (ijtag_select),
        .ijtag_capture (ijtag_capture),
        .ijtag_shift   (ijtag_shift),
        .ijtag_update  (ijtag_update),
        .ijtag_tdi     (ijtag_tdi),
        .ijtag_tdo     (ijtag_tdo),
        .status_in     (status_in),
        .ctrl_out      (ctrl_out),
        .ctrl_strobe   (ctrl_strobe),
        .sib_open      (sib_open),
        .update_count  (update_count)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    typedef struct {
        string      name;
        logic       sel, cap, sh, upd, tdi;
        logic [7:0] status;
        logic       e_tdo, e_open;
        logic [7:0] e_ctrl;
        logic       e_stb;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge TCK);
        #1;
    endtask

    task automatic idle();
        ijtag_capture = 1'b0;
        ijtag_shift   = 1'b0;
        ijtag_update  = 1'b0;
        step();
    endtask

    task automatic do_capture();
        ijtag_select  = 1'b1;
        ijtag_capture = 1'b1;
        step();
        ijtag_capture = 1'b0;
    endtask

    task automatic do_update();
        ijtag_select = 1'b1;
        ijtag_update = 1'b1;
        step();
        ijtag_update = 1'b0;
    endtask

    // Each shift compares the tdo bit presented before the edge with the queue head.
    task automatic shift_bits(input logic [15:0] bits, input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            ijtag_select = 1'b1;
            ijtag_shift  = 1'b1;
            ijtag_tdi    = bits[i];
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tdo_scan: got %0b expected <queue empty>", ijtag_tdo);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("tdo_scan[%0d]", i), {31'd0, ijtag_tdo}, {31'd0, e});
            end
            step();
        end
        ijtag_shift = 1'b0;
        ijtag_tdi   = 1'b0;
    endtask

    task automatic push_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_cnt;

        //        name          sel cap sh upd tdi status tdo open ctrl stb cnt
        vecs[0]  = '{"cap_closed",  1, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'd0};
        vecs[1]  = '{"sh_closed",   1, 0, 1, 0, 1, 8'h00, 1, 0, 8'h00, 0, 8'd0};
        vecs[2]  = '{"upd_open",    1, 0, 0, 1, 0, 8'h00, 1, 1, 8'h00, 0, 8'd0};
        vecs[3]  = '{"idle0",       1, 0, 0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 8'd0};
        vecs[4]  = '{"sel_low",     0, 1, 1, 1, 0, 8'h00, 1, 1, 8'h00, 0, 8'd0};
        vecs[5]  = '{"cap_and_upd", 1, 1, 0, 1, 0, 8'h77, 1, 1, 8'h00, 0, 8'd0};
        vecs[6]  = '{"cap_upd_hold",1, 1, 0, 1, 0, 8'h11, 1, 1, 8'h00, 0, 8'd0};
        vecs[7]  = '{"idle1",       1, 0, 0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 8'd0};
        vecs[8]  = '{"upd_commit",  1, 0, 0, 1, 0, 8'h00, 1, 1, 8'h77, 1, 8'd1};
        vecs[9]  = '{"upd_held2",   1, 0, 0, 1, 0, 8'h00, 1, 1, 8'h77, 0, 8'd1};
        vecs[10] = '{"upd_held3",   1, 0, 0, 1, 0, 8'h00, 1, 1, 8'h77, 0, 8'd1};
        vecs[11] = '{"idle2",       1, 0, 0, 0, 0, 8'h00, 1, 1, 8'h77, 0, 8'd1};

        TRST_n = 1'b0;
        ijtag_select = 1'b0; ijtag_capture = 1'b0; ijtag_shift = 1'b0;
        ijtag_update = 1'b0; ijtag_tdi = 1'b0; status_in = 8'h00;
        step();
        step();
        #2 TRST_n = 1'b1;
        step();
        check("rst_tdo",   {31'd0, ijtag_tdo},   32'd0);
        check("rst_open",  {31'd0, sib_open},    32'd0);
        check("rst_ctrl",  {24'd0, ctrl_out},    32'h00);
        check("rst_count", {24'd0, update_count}, 32'd0);

        // Single-cycle control behaviour from the table.
        for (int r = 0; r < 12; r++) begin
            ijtag_select  = vecs[r].sel;
            ijtag_capture = vecs[r].cap;
            ijtag_shift   = vecs[r].sh;
            ijtag_update  = vecs[r].upd;
            ijtag_tdi     = vecs[r].tdi;
            status_in     = vecs[r].status;
            step();
            check({vecs[r].name, "_tdo"},   {31'd0, ijtag_tdo},    {31'd0, vecs[r].e_tdo});
            check({vecs[r].name, "_open"},  {31'd0, sib_open},     {31'd0, vecs[r].e_open});
            check({vecs[r].name, "_ctrl"},  {24'd0, ctrl_out},     {24'd0, vecs[r].e_ctrl});
            check({vecs[r].name, "_stb"},   {31'd0, ctrl_strobe},  {31'd0, vecs[r].e_stb});
            check({vecs[r].name, "_count"}, {24'd0, update_count}, {24'd0, vecs[r].e_cnt});
        end
        ijtag_capture = 1'b0; ijtag_update = 1'b0;

        // Asynchronous reset in the middle of a shift.
        ijtag_select = 1'b1; ijtag_shift = 1'b1; ijtag_tdi = 1'b1;
        step();
        #2 TRST_n = 1'b0;
        #1;
        check("arst_tdo",    {31'd0, ijtag_tdo},    32'd0);
        check("arst_open",   {31'd0, sib_open},     32'd0);
        check("arst_ctrl",   {24'd0, ctrl_out},     32'h00);
        check("arst_count",  {24'd0, update_count}, 32'd0);
        check("arst_strobe", {31'd0, ctrl_strobe},  32'd0);
        ijtag_shift = 1'b0; ijtag_tdi = 1'b0;
        step();
        #2 TRST_n = 1'b1;
        idle();

        // Open request on a closed SIB.
        do_capture();
        push_bits(16'h0000, 1);
        shift_bits(16'h0001, 1);
        do_update();
        check("req_open",   {31'd0, sib_open},     32'd1);
        check("req_ctrl",   {24'd0, ctrl_out},     32'h00);
        check("req_strobe", {31'd0, ctrl_strobe},  32'd0);
        check("req_count",  {24'd0, update_count}, 32'd0);
        idle();

        // Open write/read: captured 3C scans out behind the SIB bit.
        status_in = 8'h3C;
        do_capture();
        push_bits(16'b0_0011_1100_1, 9);
        shift_bits({7'd0, 8'hA5, 1'b1}, 9);
        check("wr_scan_left", exp_q.size(), 32'd0);
        do_update();
        check("wr_ctrl",    {24'd0, ctrl_out},     32'hA5);
        check("wr_strobe",  {31'd0, ctrl_strobe},  32'd1);
        check("wr_count",   {24'd0, update_count}, 32'd1);
        check("wr_open",    {31'd0, sib_open},     32'd1);
        idle();
        check("wr_strobe_off", {31'd0, ctrl_strobe}, 32'd0);

        // Close with commit.
        do_capture();
        push_bits(16'b0_0011_1100_1, 9);
        shift_bits({7'd0, 8'h5A, 1'b0}, 9);
        do_update();
        check("cl_ctrl",   {24'd0, ctrl_out},     32'h5A);
        check("cl_open",   {31'd0, sib_open},     32'd0);
        check("cl_count",  {24'd0, update_count}, 32'd2);
        check("cl_strobe", {31'd0, ctrl_strobe},  32'd1);
        idle();

        // Closed path: tdo echoes tdi one cycle later.
        do_capture();
        push_bits(16'b10, 2);
        shift_bits(16'b01, 2);
        check("byp_tdo", {31'd0, ijtag_tdo}, 32'd0);
        idle();

        // Reopen, then saturate the counter.
        do_capture();
        push_bits(16'h0000, 1);
        shift_bits(16'h0001, 1);
        do_update();
        check("reopen_open",  {31'd0, sib_open},     32'd1);
        check("reopen_count", {24'd0, update_count}, 32'd2);
        idle();
        exp_cnt = 8'd2;
        for (int k = 0; k < 260; k++) begin
            do_update();
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            check("sat_strobe", {31'd0, ctrl_strobe},  32'd1);
            check("sat_count",  {24'd0, update_count}, {24'd0, exp_cnt});
            idle();
            check("sat_strobe_off", {31'd0, ctrl_strobe}, 32'd0);
        end
        check("sat_final", {24'd0, update_count}, 32'd255);
        check("sat_ctrl",  {24'd0, ctrl_out},     32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
